// File: rtl/plic_pkg.sv
// Shared definitions for the PLIC access sequencers: FSM state encoding,
// access-type codes and a width helper used to size select and counter fields.
package plic_pkg;

    // Claim/complete sequencer states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STROBE = 2'd1,
        SETTLE = 2'd2,
        RESP   = 2'd3
    } plic_state_e;

    // Bus access type as carried on we_i
    localparam logic ACC_CLAIM    = 1'b0;
    localparam logic ACC_COMPLETE = 1'b1;

    // Width of a field that must index n items, never narrower than one bit
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/plic_claim_ctrl_if.sv
// Register-bus side of the claim/complete sequencer: one request/acknowledge
// handshake carrying the access type, target, write ID and read-back data.
interface plic_claim_ctrl_if #(
    parameter int SOURCES_BITS = 4,
    parameter int TARGET_BITS  = 1
) ();

    logic                    req_i;
    logic                    we_i;
    logic [TARGET_BITS-1:0]  tgt_i;
    logic [SOURCES_BITS-1:0] wdata_i;
    logic                    ack_o;
    logic [SOURCES_BITS-1:0] rdata_o;
    logic                    err_o;

    // Bus-interface decoder side: issues accesses and waits for ack
    modport master (
        output req_i, we_i, tgt_i, wdata_i,
        input  ack_o, rdata_o, err_o
    );

    // Sequencer side: accepts accesses and returns the response
    modport slave (
        input  req_i, we_i, tgt_i, wdata_i,
        output ack_o, rdata_o, err_o
    );

endinterface

// File: rtl/plic_settle_timer.sv
// Loadable down-counter with a done flag. Loading takes priority over counting;
// the count sticks at zero, where done stays asserted until the next load.
module plic_settle_timer
    import plic_pkg::*;
#(
    parameter int WIDTH = clog2_min1(4)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic             done
);

    logic [WIDTH-1:0] cnt;

    // Count register: load the wait length, then decrement toward zero while enabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - WIDTH'(1);
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/plic_claim_ctrl.sv
// Claim/complete sequencer between the PLIC bus decoder and the PLIC core.
// A claim read returns the core's current highest-priority ID for the target
// and pulses claim_o; a complete write is checked against the ID last claimed
// on that target and pulses complete_o. After any strobe the response is held
// back for SETTLE_CYCLES so the core's ID/priority pipeline has caught up
// before the next access can sample it.
module plic_claim_ctrl
    import plic_pkg::*;
#(
    parameter int SOURCES       = 8,
    parameter int TARGETS       = 1,
    parameter int SETTLE_CYCLES = 3,
    parameter int SOURCES_BITS  = $clog2(SOURCES + 1),
    parameter int TARGET_BITS   = clog2_min1(TARGETS)
) (
    input  logic                                 rst_n,
    input  logic                                 clk,
    plic_claim_ctrl_if.slave                     bus,
    input  logic [TARGETS-1:0]                   ireq_i,
    input  logic [TARGETS-1:0][SOURCES_BITS-1:0] id_i,
    output logic [TARGETS-1:0]                   claim_o,
    output logic [TARGETS-1:0]                   complete_o
);

    // The counter is loaded in STROBE with SETTLE_CYCLES-1, so SETTLE lasts
    // exactly SETTLE_CYCLES cycles and strobe-to-ack is SETTLE_CYCLES+1.
    localparam int               CNT_W       = clog2_min1(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    plic_state_e state;
    plic_state_e state_nxt;

    // Per-target view of the live request
    logic [TARGETS-1:0]      tgt_oh;
    logic                    tgt_ok;
    logic                    sel_ireq;
    logic [SOURCES_BITS-1:0] sel_id;
    logic [SOURCES_BITS-1:0] sel_ins;

    // Outcome of the access, decided in IDLE
    logic                    accept;
    logic                    go_strobe;
    logic                    acc_err;
    logic [SOURCES_BITS-1:0] acc_rdata;

    // Access context held for the remaining states
    logic [TARGETS-1:0]      tgt_oh_q;
    logic                    we_q;
    logic [SOURCES_BITS-1:0] rdata_q;
    logic                    err_q;

    // ID last claimed per target; 0 means nothing in service
    logic [TARGETS-1:0][SOURCES_BITS-1:0] in_service;

    // Settle timer handshake
    logic tmr_load;
    logic tmr_en;
    logic tmr_done;

    plic_settle_timer #(
        .WIDTH (CNT_W)
    ) u_settle_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (SETTLE_LOAD),
        .en       (tmr_en),
        .done     (tmr_done)
    );

    // Decode the addressed target one-hot and pick out its core inputs and in-service ID;
    // an address beyond TARGETS decodes to no target at all
    always_comb begin
        tgt_oh   = '0;
        sel_ireq = 1'b0;
        sel_id   = '0;
        sel_ins  = '0;
        for (int t = 0; t < TARGETS; t++) begin
            if (bus.tgt_i == TARGET_BITS'(t)) begin
                tgt_oh[t] = 1'b1;
                sel_ireq  = ireq_i[t];
                sel_id    = id_i[t];
                sel_ins   = in_service[t];
            end
        end
        tgt_ok = |tgt_oh;
    end

    // Classify the access: strobed claim/complete, empty claim, or rejected access
    always_comb begin
        go_strobe = 1'b0;
        acc_err   = 1'b0;
        acc_rdata = '0;
        if (!tgt_ok) begin
            acc_err = 1'b1;
        end else if (bus.we_i == ACC_CLAIM) begin
            if (sel_ireq) begin
                go_strobe = 1'b1;
                acc_rdata = sel_id;
            end
        end else if ((bus.wdata_i != '0) && (bus.wdata_i == sel_ins)) begin
            go_strobe = 1'b1;
        end else begin
            acc_err = 1'b1;
        end
    end

    // Requests are only looked at in IDLE; everything else ignores req_i
    assign accept = (state == IDLE) && bus.req_i;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.req_i) begin
                    state_nxt = go_strobe ? STROBE : RESP;
                end
            end
            STROBE: state_nxt = SETTLE;
            SETTLE: begin
                if (tmr_done) begin
                    state_nxt = RESP;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode: strobes in STROBE, timer control, response only in RESP
    always_comb begin
        claim_o     = '0;
        complete_o  = '0;
        tmr_load    = 1'b0;
        tmr_en      = 1'b0;
        bus.ack_o   = 1'b0;
        bus.rdata_o = '0;
        bus.err_o   = 1'b0;
        case (state)
            STROBE: begin
                tmr_load = 1'b1;
                if (we_q == ACC_CLAIM) begin
                    claim_o = tgt_oh_q;
                end else begin
                    complete_o = tgt_oh_q;
                end
            end
            SETTLE: tmr_en = 1'b1;
            RESP: begin
                bus.ack_o   = 1'b1;
                bus.rdata_o = rdata_q;
                bus.err_o   = err_q;
            end
            default: ;
        endcase
    end

    // Capture the access context; only consumed in states reached via accept,
    // so it needs no reset
    always_ff @(posedge clk) begin
        if (accept) begin
            tgt_oh_q <= tgt_oh;
            we_q     <= bus.we_i;
            rdata_q  <= acc_rdata;
            err_q    <= acc_err;
        end
    end

    // Track the in-service ID: a strobed claim records (or overwrites) the
    // claimed ID, a strobed complete clears it back to 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_service <= '0;
        end else if (accept && go_strobe) begin
            for (int t = 0; t < TARGETS; t++) begin
                if (tgt_oh[t]) begin
                    in_service[t] <= (bus.we_i == ACC_CLAIM) ? sel_id : '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_plic_claim_ctrl.sv
// Bench for plic_claim_ctrl: directed steps for the documented scenarios
// followed by randomized accesses, all judged against an access-level model
// that tracks the in-service ID per target and derives rdata/err/strobe/latency.
module tb_plic_claim_ctrl;

    localparam int NT = 2;
    localparam int SB = 4;
    localparam int TB = 2;
    localparam int SC = 3;

    logic                 clk;
    logic                 rst_n;
    logic [NT-1:0]        ireq_v;
    logic [NT-1:0][SB-1:0] id_v;
    logic [NT-1:0]        claim_o;
    logic [NT-1:0]        complete_o;

    int checks;
    int errors;
    int ins_m [NT];

    plic_claim_ctrl_if #(.SOURCES_BITS(SB), .TARGET_BITS(TB)) bus_if ();

    plic_claim_ctrl #(
        .SOURCES       (8),
        .TARGETS       (NT),
        .SETTLE_CYCLES (SC),
        .SOURCES_BITS  (SB),
        .TARGET_BITS   (TB)
    ) dut (
        .rst_n      (rst_n),
        .clk        (clk),
        .bus        (bus_if),
        .ireq_i     (ireq_v),
        .id_i       (id_v),
        .claim_o    (claim_o),
        .complete_o (complete_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One bus access, judged against the model; perturb scrambles ireq/id
    // mid-access to show the captured ID does not follow them
    task automatic do_access(input logic we, input int tgt, input logic [SB-1:0] wdata,
                             input bit perturb);
        int            exp_lat;
        logic          exp_err;
        logic [SB-1:0] exp_rd;
        logic [NT-1:0] exp_claim;
        logic [NT-1:0] exp_comp;
        int            claim_cnt, comp_cnt, both_cnt, strobe_k, k, ack_k;
        logic [NT-1:0] claim_seen, comp_seen;
        logic [SB-1:0] rd;
        logic          er;
        bit            got;

        exp_err = 1'b0; exp_rd = '0; exp_claim = '0; exp_comp = '0; exp_lat = 1;
        if (tgt >= NT) begin
            exp_err = 1'b1;
        end else if (!we) begin
            if (ireq_v[tgt]) begin
                exp_rd       = id_v[tgt];
                exp_claim    = NT'(1 << tgt);
                exp_lat      = 2 + SC;
                ins_m[tgt]   = int'(id_v[tgt]);
            end
        end else if (wdata != 0 && int'(wdata) == ins_m[tgt]) begin
            exp_comp   = NT'(1 << tgt);
            exp_lat    = 2 + SC;
            ins_m[tgt] = 0;
        end else begin
            exp_err = 1'b1;
        end

        @(negedge clk);
        bus_if.req_i   = 1'b1;
        bus_if.we_i    = we;
        bus_if.tgt_i   = TB'(tgt);
        bus_if.wdata_i = wdata;

        claim_cnt = 0; comp_cnt = 0; both_cnt = 0; strobe_k = 0; k = 0; ack_k = 0;
        claim_seen = '0; comp_seen = '0; rd = '0; er = 1'b0; got = 0;
        while (!got && k < 20) begin
            k++;
            @(posedge clk);
            #1;
            if (claim_o != 0 && complete_o != 0) both_cnt++;
            if (claim_o != 0) begin claim_cnt++; claim_seen |= claim_o; strobe_k = k; end
            if (complete_o != 0) begin comp_cnt++; comp_seen |= complete_o; strobe_k = k; end
            if (bus_if.ack_o) begin
                got = 1; ack_k = k; rd = bus_if.rdata_o; er = bus_if.err_o;
                bus_if.req_i = 1'b0;
            end
            if (perturb && k == 2) begin
                ireq_v  = NT'($urandom);
                id_v[0] = SB'($urandom_range(1, 8));
                id_v[1] = SB'($urandom_range(1, 8));
            end
        end
        bus_if.req_i = 1'b0;

        chk("ack_seen", 32'(got), 32'd1);
        chk("ack_latency", ack_k, exp_lat);
        chk("rdata", rd, exp_rd);
        chk("err", er, exp_err);
        chk("claim_value", claim_seen, exp_claim);
        chk("claim_cycles", claim_cnt, (exp_claim != 0) ? 1 : 0);
        chk("complete_value", comp_seen, exp_comp);
        chk("complete_cycles", comp_cnt, (exp_comp != 0) ? 1 : 0);
        chk("strobe_overlap", both_cnt, 0);
        if (exp_claim != 0 || exp_comp != 0) chk("strobe_cycle", strobe_k, 1);

        @(posedge clk);
        #1;
        chk("ack_single_cycle", bus_if.ack_o, 1'b0);
        chk("rdata_idle_zero", bus_if.rdata_o, '0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        ins_m[0] = 0;
        ins_m[1] = 0;
        rst_n = 1'b0;
        bus_if.req_i = 1'b0; bus_if.we_i = 1'b0; bus_if.tgt_i = '0; bus_if.wdata_i = '0;
        ireq_v = '0;
        id_v   = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack", bus_if.ack_o, 1'b0);
        chk("rst_rdata", bus_if.rdata_o, '0);
        chk("rst_err", bus_if.err_o, 1'b0);
        chk("rst_claim", claim_o, '0);
        chk("rst_complete", complete_o, '0);
        @(negedge clk);
        rst_n = 1'b1;

        // Claim with pending source on target 0, ID 5
        ireq_v  = 2'b01;
        id_v[0] = 4'd5;
        id_v[1] = 4'd7;
        do_access(1'b0, 0, 4'd0, 0);
        // Claim with nothing pending on target 1
        do_access(1'b0, 1, 4'd0, 0);
        // Matching complete of ID 5
        do_access(1'b1, 0, 4'd5, 0);
        chk("ins_cleared_model", ins_m[0], 0);
        // Reclaim ID 5, then mismatched and zero completes
        do_access(1'b0, 0, 4'd0, 0);
        do_access(1'b1, 0, 4'd3, 0);
        do_access(1'b1, 0, 4'd0, 0);
        // Claim on an already in-service target overwrites it
        id_v[0] = 4'd2;
        do_access(1'b0, 0, 4'd0, 0);
        do_access(1'b1, 0, 4'd5, 0);
        // Bad target, claim and complete
        do_access(1'b0, 3, 4'd0, 0);
        do_access(1'b1, 3, 4'd2, 0);

        // Reset in the middle of a strobed claim on target 1
        ireq_v  = 2'b10;
        id_v[1] = 4'd6;
        @(negedge clk);
        bus_if.req_i = 1'b1; bus_if.we_i = 1'b0; bus_if.tgt_i = 2'd1; bus_if.wdata_i = '0;
        @(posedge clk);
        #1;
        chk("mid_claim_strobe", claim_o, 2'b10);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        bus_if.req_i = 1'b0;
        #1;
        chk("mid_rst_claim", claim_o, '0);
        chk("mid_rst_complete", complete_o, '0);
        chk("mid_rst_ack", bus_if.ack_o, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("mid_rst_no_ack", bus_if.ack_o, 1'b0);
        end
        ins_m[0] = 0;
        ins_m[1] = 0;
        @(negedge clk);
        rst_n = 1'b1;
        do_access(1'b1, 1, 4'd6, 0);
        do_access(1'b1, 0, 4'd2, 0);

        // Randomized accesses
        for (int n = 0; n < 60; n++) begin
            int            t;
            logic          w;
            logic [SB-1:0] wd;
            ireq_v  = NT'($urandom);
            id_v[0] = SB'($urandom_range(1, 8));
            id_v[1] = SB'($urandom_range(1, 8));
            t  = $urandom_range(0, 3);
            w  = 1'($urandom);
            wd = SB'($urandom_range(0, 15));
            if (t < NT && $urandom_range(0, 1) == 1) wd = SB'(ins_m[t]);
            do_access(w, t, wd, 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
